// File: rtl/can_tx_queue_pkg.sv
// Shared widths, FSM encoding and frame layout for the CAN transmit queue.
package can_tx_queue_pkg;

    localparam int CAN_ID_W     = 11;
    localparam int CAN_TXDATA_W = 32;
    localparam int TXQ_FRAME_W  = CAN_ID_W + CAN_TXDATA_W;

    typedef enum logic [1:0] {
        TXQ_IDLE   = 2'd0,
        TXQ_SEND   = 2'd1,
        TXQ_REPORT = 2'd2
    } txq_state_e;

    typedef struct packed {
        logic [CAN_ID_W-1:0]     id;
        logic [CAN_TXDATA_W-1:0] data;
    } txq_frame_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/can_tx_queue_fifo.sv
// Synchronous ID+payload FIFO with single-cycle flush; count excludes nothing in flight.
module can_tx_fifo
    import can_tx_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       wr_en,
    input  txq_frame_t                 wr_frame,
    input  logic                       rd_en,
    output txq_frame_t                 rd_frame,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    txq_frame_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push;
    logic          pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = wr_en && !full;
    assign pop      = rd_en && !empty;
    assign rd_frame = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_frame;
        end
    end

    // flush outranks both push and pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/can_tx_queue.sv
// Transmit frame queue: holds one frame on the controller TX port, retries un-ACKed
// frames, bounds each frame with a watchdog and reports a completion status.
//   state  | meaning
//   IDLE   | no frame in flight; load head when queue non-empty
//   SEND   | tx_start high, waiting for tx_done or watchdog expiry
//   REPORT | one-cycle done_valid pulse, then back to IDLE
module can_tx_queue
    import can_tx_queue_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [3:0]  MAX_RETRY  = 4'd3,
    parameter logic [23:0] TMO_CYCLES = 24'd5_000_000
) (
    input  logic                     rstn,
    input  logic                     clk,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CAN_ID_W-1:0]      wr_id,
    input  logic [CAN_TXDATA_W-1:0]  wr_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done_valid,
    output logic                     done_ok,
    output logic                     done_timeout,
    output logic [CAN_ID_W-1:0]      done_id,
    output logic [3:0]               done_attempts,
    output logic                     tx_start,
    output logic [CAN_ID_W-1:0]      tx_id,
    output logic [CAN_TXDATA_W-1:0]  tx_data,
    input  logic                     tx_done,
    input  logic                     tx_acked
);
    localparam logic [23:0] TMO_LOAD = TMO_CYCLES - 24'd1;

    txq_state_e  state, state_nx;
    logic [3:0]  attempts, attempts_nx;
    logic [23:0] timer, timer_nx;
    logic        ok_nx, tmo_nx;
    logic        empty, full, load;
    txq_frame_t  head;

    assign wr_ready = !full && !flush;
    assign load     = (state == TXQ_IDLE) && !empty;

    can_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .wr_en    (wr_valid && wr_ready),
        .wr_frame ('{id: wr_id, data: wr_data}),
        .rd_en    (load),
        .rd_frame (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    // watchdog is a down-counter; expiry is terminal count 0 while in SEND
    always_comb begin
        state_nx    = state;
        attempts_nx = attempts;
        timer_nx    = timer;
        ok_nx       = 1'b0;
        tmo_nx      = 1'b0;
        case (state)
            TXQ_IDLE: begin
                if (!empty) begin
                    state_nx    = TXQ_SEND;
                    attempts_nx = 4'd0;
                    timer_nx    = TMO_LOAD;
                end
            end
            TXQ_SEND: begin
                if (tx_done) begin
                    attempts_nx = sat_inc4(attempts);
                    if (tx_acked) begin
                        state_nx = TXQ_REPORT;
                        ok_nx    = 1'b1;
                    end else if (attempts < MAX_RETRY) begin
                        timer_nx = TMO_LOAD;
                    end else begin
                        state_nx = TXQ_REPORT;
                    end
                end else if ((TMO_CYCLES != 24'd0) && (timer == 24'd0)) begin
                    state_nx = TXQ_REPORT;
                    tmo_nx   = 1'b1;
                end else if (timer != 24'd0) begin
                    timer_nx = timer - 24'd1;
                end
            end
            TXQ_REPORT: state_nx = TXQ_IDLE;
            default:    state_nx = TXQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= TXQ_IDLE;
            attempts      <= 4'd0;
            timer         <= 24'd0;
            tx_start      <= 1'b0;
            tx_id         <= '0;
            tx_data       <= '0;
            busy          <= 1'b0;
            done_valid    <= 1'b0;
            done_ok       <= 1'b0;
            done_timeout  <= 1'b0;
            done_id       <= '0;
            done_attempts <= 4'd0;
        end else begin
            state      <= state_nx;
            attempts   <= attempts_nx;
            timer      <= timer_nx;
            tx_start   <= (state_nx == TXQ_SEND);
            busy       <= (state_nx != TXQ_IDLE);
            done_valid <= (state_nx == TXQ_REPORT);
            if (load) begin
                tx_id   <= head.id;
                tx_data <= head.data;
            end
            if ((state == TXQ_SEND) && (state_nx == TXQ_REPORT)) begin
                done_ok       <= ok_nx;
                done_timeout  <= tmo_nx;
                done_id       <= tx_id;
                done_attempts <= attempts_nx;
            end
        end
    end

endmodule
